divider_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one signed 32-bit iterative divider (start/ready handshake, `divider_dshift` port set) among NUM_REQ requesters. It sits between the requesting datapath blocks and the divider. It captures the winning requester's operands, drives the divider handshake, and returns the quotient and remainder on a shared response bus with a one-hot done pulse. A watchdog aborts a divide whose ready never arrives.

---
 rtl/divider_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_divider_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_arbiter.sv
// ---------------------------------------------------------------------------
// divider_arbiter
//
// Shares one iterative signed divider among NUM_REQ requesters. A round-robin
// pick is made in IDLE, the winner's operands are captured and presented to
// the divider with a start/ready handshake, and the divider results are
// returned on a shared response bus with a one-hot done pulse. A watchdog
// aborts a divide whose ready never arrives (TIMEOUT = 0 disables it).
//
// State table
//   state | meaning
//   IDLE  | waiting for any req; picks winner, captures operands, pulses ack
//   BUSY  | div_start held high until div_ready or watchdog expiry
//   RESP  | div_start low; done[id] and rsp_* valid for one cycle
//
// Ports
//   clk            in   clock, all logic on rising edge
//   rst            in   synchronous active-low reset
//   req            in   [NUM_REQ]        level request per requester
//   req_dividend   in   [NUM_REQ*WIDTH]  dividend, slice i = requester i
//   req_divisor    in   [NUM_REQ*WIDTH]  divisor,  slice i = requester i
//   ack            out  [NUM_REQ]        one-hot pulse: operands captured
//   done           out  [NUM_REQ]        one-hot pulse: response valid
//   rsp_quotient   out  [WIDTH]          quotient for the done requester
//   rsp_remainder  out  [WIDTH]          remainder for the done requester
//   rsp_id         out  [ID_W]           index of the done requester
//   rsp_err        out  1                1 = watchdog abort (results zero)
//   div_start      out  1                divider start
//   div_dividend   out  [WIDTH]          divider dividend
//   div_divisor    out  [WIDTH]          divider divisor
//   div_ready      in   1                divider ready (results valid)
//   div_quotient   in   [WIDTH]          divider quotient
//   div_remainder  in   [WIDTH]          divider remainder
// ---------------------------------------------------------------------------
module divider_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  WIDTH   = 32,
    parameter int  TIMEOUT = 64,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       done,
    output logic [WIDTH-1:0]         rsp_quotient,
    output logic [WIDTH-1:0]         rsp_remainder,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_err,
    output logic                     div_start,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    input  logic                     div_ready,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_remainder
);

    // Watchdog only has to count up to TIMEOUT itself.
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [ID_W-1:0]    r_last_grant;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    r_rsp_id;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_idx;
    logic               w_found;
    logic [NUM_REQ-1:0] w_winner_onehot;

    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] w_done;
    logic               w_div_start;

    logic [WIDTH-1:0]   r_div_dividend;
    logic [WIDTH-1:0]   r_div_divisor;
    logic [WIDTH-1:0]   r_rsp_quotient;
    logic [WIDTH-1:0]   r_rsp_remainder;
    logic               r_rsp_err;

    logic [WD_W-1:0]    r_wd;
    logic               w_wd_expired;

    // -----------------------------------------------------------------------
    // Round-robin pick: first set req scanning upward from last_grant+1,
    // wrapping. last_grant itself is checked last, so a requester that holds
    // req high can never win twice in a row while another is waiting.
    // -----------------------------------------------------------------------
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_winner_onehot = NUM_REQ'(1) << w_winner;

    // The abort fires in the BUSY cycle where the count equals TIMEOUT, so
    // the aborted done lands TIMEOUT+1 cycles after the ack cycle.
    assign w_wd_expired = (TIMEOUT != 0) && (r_wd == WD_W'(TIMEOUT));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_div_start  = 1'b0;
        w_done       = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                w_div_start = 1'b1;
                if (div_ready || w_wd_expired) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_done       = NUM_REQ'(1) << r_id;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Grant bookkeeping and operand capture (IDLE -> BUSY)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_grant   <= ID_W'(NUM_REQ - 1);
            r_id           <= '0;
            r_ack          <= '0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
        end else begin
            r_ack <= '0;
            if (r_state == IDLE && w_found) begin
                r_last_grant   <= w_winner;
                r_id           <= w_winner;
                r_ack          <= w_winner_onehot;
                r_div_dividend <= req_dividend[int'(w_winner)*WIDTH +: WIDTH];
                r_div_divisor  <= req_divisor[int'(w_winner)*WIDTH +: WIDTH];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Watchdog: cleared on entry to BUSY, counts every BUSY cycle
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wd <= '0;
        end else if (r_state == IDLE && w_found) begin
            r_wd <= '0;
        end else if (r_state == BUSY && TIMEOUT != 0 && !w_wd_expired) begin
            r_wd <= r_wd + WD_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Response registers (BUSY -> RESP). Held afterwards until the next
    // response overwrites them; done is what qualifies them.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_err       <= 1'b0;
            r_rsp_id        <= '0;
        end else if (r_state == BUSY) begin
            if (div_ready) begin
                r_rsp_quotient  <= div_quotient;
                r_rsp_remainder <= div_remainder;
                r_rsp_err       <= 1'b0;
                r_rsp_id        <= r_id;
            end else if (w_wd_expired) begin
                r_rsp_quotient  <= '0;
                r_rsp_remainder <= '0;
                r_rsp_err       <= 1'b1;
                r_rsp_id        <= r_id;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign ack           = r_ack;
    assign done          = w_done;
    assign rsp_quotient  = r_rsp_quotient;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_id        = r_rsp_id;
    assign rsp_err       = r_rsp_err;
    assign div_start     = w_div_start;
    assign div_dividend  = r_div_dividend;
    assign div_divisor   = r_div_divisor;

endmodule

// File: tb/tb_divider_arbiter.sv
// ---------------------------------------------------------------------------
// tb_divider_arbiter
//
// Bench for divider_arbiter with NUM_REQ=4, WIDTH=32, TIMEOUT=16. A stub
// divider answers after a random latency (or never, when stub_hang is set).
// Expected grant order comes from a round-robin model over request sets and
// expected results from sign/magnitude arithmetic.
// ---------------------------------------------------------------------------
module tb_divider_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*W-1:0]   req_dividend;
    logic [NR*W-1:0]   req_divisor;
    logic [NR-1:0]     ack;
    logic [NR-1:0]     done;
    logic [W-1:0]      rsp_quotient;
    logic [W-1:0]      rsp_remainder;
    logic [1:0]        rsp_id;
    logic              rsp_err;
    logic              div_start;
    logic [W-1:0]      div_dividend;
    logic [W-1:0]      div_divisor;
    logic              div_ready;
    logic [W-1:0]      div_quotient;
    logic [W-1:0]      div_remainder;

    always #5 clk = ~clk;

    divider_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .ack(ack), .done(done),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    // ---------------- stub divider ----------------
    logic stub_hang = 1'b0;
    logic stub_active;
    int   stub_cnt;

    function automatic logic [63:0] stub_div(input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic [31:0] q, r;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'hFFFF_FFFF) begin
            q = ~a + 32'd1;
            r = 32'd0;
        end else if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {q, r};
    endfunction

    always @(posedge clk) begin
        if (!rst || !div_start || stub_hang) begin
            div_ready   <= 1'b0;
            stub_active <= 1'b0;
        end else if (!stub_active) begin
            stub_active <= 1'b1;
            stub_cnt    <= int'($urandom_range(0, 4));
        end else if (div_ready) begin
            div_ready <= 1'b0;
        end else if (stub_cnt == 0) begin
            div_ready <= 1'b1;
            {div_quotient, div_remainder} <= stub_div(div_dividend, div_divisor);
        end else begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ma, mb, mq, mr, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        mq = ma / mb;
        mr = ma - mq * mb;
        q  = ((sa < 0) != (sb < 0)) ? -mq : mq;
        r  = (sa < 0) ? -mr : mr;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] mask, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (mask[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_order(input logic [NR-1:0] mask, input int last_in,
                               output int order[$], output int last_out);
        logic [NR-1:0] pend;
        int last, c;
        pend  = mask;
        last  = last_in;
        order = {};
        while (pend != 0) begin
            c = rr_pick(pend, last);
            order.push_back(c);
            pend[c] = 1'b0;
            last = c;
        end
        last_out = last;
    endtask

    // ---------------- observation log ----------------
    typedef struct {
        int          id;
        logic [3:0]  raw;
        logic [1:0]  rid;
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
        logic        start;
        int          cyc;
    } done_t;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [NR-1:0] hold_mask = '0;
    int            ack_log[$];
    int            ack_cyc[$];
    done_t         done_log[$];
    logic [31:0]   opa[NR];
    logic [31:0]   opb[NR];
    logic          prev_start = 1'b0;
    logic          seen_start = 1'b0;
    int            low_run = 0;
    int            min_gap = 1000;

    function automatic int low_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_logs();
        ack_log.delete();
        ack_cyc.delete();
        done_log.delete();
        seen_start = 1'b0;
        low_run    = 0;
        min_gap    = 1000;
    endtask

    // One cycle: sample at the falling edge, log events, drop acked requests.
    task automatic tick();
        done_t d;
        @(negedge clk);
        cyc++;
        if (div_start) begin
            if (!prev_start && seen_start && low_run < min_gap) min_gap = low_run;
            seen_start = 1'b1;
            low_run    = 0;
        end else begin
            low_run++;
        end
        prev_start = div_start;
        if (ack != 0) begin
            ack_log.push_back(low_idx(ack));
            ack_cyc.push_back(cyc);
            req = req & ~(ack & ~hold_mask);
        end
        if (done != 0) begin
            d.id = low_idx(done); d.raw = done; d.rid = rsp_id;
            d.q = rsp_quotient; d.r = rsp_remainder; d.err = rsp_err;
            d.start = div_start; d.cyc = cyc;
            done_log.push_back(d);
        end
    endtask

    task automatic wait_dones(input int n, input int budget, output bit ok);
        int t;
        t = 0;
        while (done_log.size() < n && t < budget) begin
            tick();
            t++;
        end
        ok = (done_log.size() >= n);
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        opa[i] = a;
        opb[i] = b;
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
    endtask

    task automatic rand_op(input int i);
        logic [31:0] b;
        b = $urandom;
        if (b == 32'd0) b = 32'd1;
        set_op(i, $urandom, b);
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; hold_mask = '0;
        tick(); tick();
        rst = 1'b1;
        clear_logs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; req = '1;
        tick(); tick();
        checks++; if (ack !== '0 || done !== '0) begin failures++;
            $display("FAIL reset_pulses: ack=%b done=%b, required 0000 0000", ack, done); end
        checks++; if (div_start !== 1'b0 || rsp_err !== 1'b0) begin failures++;
            $display("FAIL reset_ctrl: div_start=%b rsp_err=%b, required 0 0", div_start, rsp_err); end
        checks++; if ({rsp_quotient, rsp_remainder, rsp_id} !== '0) begin failures++;
            $display("FAIL reset_rsp: q=%h r=%h id=%0d, required 0", rsp_quotient, rsp_remainder, rsp_id); end
        checks++; if ({div_dividend, div_divisor} !== '0) begin failures++;
            $display("FAIL reset_ops: %h/%h, required 0", div_dividend, div_divisor); end
        req = '0; rst = 1'b1;
        tick(); tick();
        checks++; if (div_start !== 1'b0 || ack !== '0) begin failures++;
            $display("FAIL reset_idle: div_start=%b ack=%b, required 0", div_start, ack); end
        clear_logs();
    endtask

    task automatic test_single();
        bit ok; int c0;
        do_reset();
        set_op(2, 32'd100, 32'd7);
        req = 4'b0100; c0 = cyc;
        wait_dones(1, 50, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout: dones=%0d, required 1", done_log.size()); end
        if (ok) begin
            checks++; if (ack_log.size() != 1 || ack_log[0] != 2 || ack_cyc[0] != c0 + 1) begin failures++;
                $display("FAIL single_ack: acks=%0d first_id=%0d at cycle %0d, required one ack id 2 at cycle %0d",
                         ack_log.size(), ack_log[0], ack_cyc[0], c0 + 1); end
            checks++; if (done_log[0].raw !== 4'b0100 || done_log[0].rid !== 2'd2) begin failures++;
                $display("FAIL single_done: done=%b id=%0d, required 0100 2", done_log[0].raw, done_log[0].rid); end
            checks++; if (done_log[0].q !== 32'd14 || done_log[0].r !== 32'd2 || done_log[0].err !== 1'b0) begin failures++;
                $display("FAIL single_result: q=%0d r=%0d err=%b, required 14 2 0",
                         $signed(done_log[0].q), $signed(done_log[0].r), done_log[0].err); end
            checks++; if (done_log[0].start !== 1'b0) begin failures++;
                $display("FAIL single_resp_start: div_start=%b in RESP, required 0", done_log[0].start); end
            tick();
            checks++; if (div_start !== 1'b0) begin failures++;
                $display("FAIL single_idle_start: div_start=%b after RESP, required 0", div_start); end
        end
    endtask

    task automatic test_signs();
        logic [31:0] ta[3], tb_[3], tq[3], tr[3];
        bit ok;
        ta  = '{32'hFFFF_FF9C, 32'd100,        32'h8000_0000};
        tb_ = '{32'd7,         32'hFFFF_FFF9,  32'hFFFF_FFFF};
        tq  = '{32'hFFFF_FFF2, 32'hFFFF_FFF2,  32'h8000_0000};
        tr  = '{32'hFFFF_FFFE, 32'd2,          32'd0};
        for (int i = 0; i < 3; i++) begin
            clear_logs();
            set_op(i, ta[i], tb_[i]);
            req = NR'(1) << i;
            wait_dones(1, 50, ok);
            checks++; if (!ok || done_log[0].id != i || done_log[0].q !== tq[i] || done_log[0].r !== tr[i] || done_log[0].err !== 1'b0) begin
                failures++;
                $display("FAIL signs_%0d: ok=%0d id=%0d q=%h r=%h err=%b, required id %0d q=%h r=%h err 0",
                         i, ok, done_log[0].id, done_log[0].q, done_log[0].r, done_log[0].err, i, tq[i], tr[i]);
            end
        end
    endtask

    task automatic check_round(input string name, input logic [NR-1:0] mask, input int last_in, output int last_out);
        int order[$]; bit ok; logic [63:0] exp;
        model_order(mask, last_in, order, last_out);
        wait_dones(order.size(), 60 * NR, ok);
        checks++; if (!ok) begin failures++;
            $display("FAIL %s_timeout: dones=%0d, required %0d", name, done_log.size(), order.size()); end
        if (ok) begin
            for (int k = 0; k < order.size(); k++) begin
                exp = model_div(opa[order[k]], opb[order[k]]);
                checks++;
                if (ack_log[k] != order[k] || done_log[k].id != order[k] || done_log[k].raw !== (NR'(1) << order[k]) ||
                    int'(done_log[k].rid) != order[k] || {done_log[k].q, done_log[k].r} !== exp || done_log[k].err !== 1'b0) begin
                    failures++;
                    $display("FAIL %s_txn%0d: ack=%0d done=%b id=%0d q=%h r=%h err=%b, required id %0d q=%h r=%h err 0",
                             name, k, ack_log[k], done_log[k].raw, done_log[k].rid, done_log[k].q, done_log[k].r,
                             done_log[k].err, order[k], exp[63:32], exp[31:0]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int last;
        do_reset();
        for (int i = 0; i < NR; i++) rand_op(i);
        req = 4'b1111;
        check_round("all4", 4'b1111, NR - 1, last);
        checks++; if (min_gap < 2) begin failures++;
            $display("FAIL start_gap: div_start low for %0d cycles, required >= 2", min_gap); end
        clear_logs();
        rand_op(0); rand_op(3);
        req = 4'b1001;
        check_round("pair03", 4'b1001, last, last);
    endtask

    task automatic test_fairness();
        bit ok; int last, exp_id; logic [63:0] exp;
        do_reset();
        rand_op(1); rand_op(2);
        hold_mask = 4'b0110;
        req = 4'b0110;
        wait_dones(6, 200, ok);
        req = '0; hold_mask = '0;
        checks++; if (!ok) begin failures++; $display("FAIL fair_timeout: dones=%0d, required 6", done_log.size()); end
        if (ok) begin
            last = NR - 1;
            for (int k = 0; k < 6; k++) begin
                exp_id = rr_pick(4'b0110, last);
                last = exp_id;
                exp = model_div(opa[exp_id], opb[exp_id]);
                checks++;
                if (done_log[k].id != exp_id || {done_log[k].q, done_log[k].r} !== exp ||
                    (k > 0 && done_log[k].id == 1 && done_log[k-1].id == 1)) begin
                    failures++;
                    $display("FAIL fair_txn%0d: id=%0d q=%h r=%h, required id %0d q=%h r=%h",
                             k, done_log[k].id, done_log[k].q, done_log[k].r, exp_id, exp[63:32], exp[31:0]);
                end
            end
        end
        repeat (12) tick();
        checks++; if (done_log.size() != 6) begin failures++;
            $display("FAIL fair_drain: dones=%0d after req dropped, required 6", done_log.size()); end
    endtask

    task automatic test_random();
        int last; logic [NR-1:0] mask;
        do_reset();
        last = NR - 1;
        for (int rnd = 0; rnd < 8; rnd++) begin
            mask = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) if (mask[i]) rand_op(i);
            clear_logs();
            req = mask;
            check_round($sformatf("rand%0d", rnd), mask, last, last);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        stub_hang = 1'b1;
        set_op(1, 32'd1234, 32'd5);
        req = 4'b0010;
        wait_dones(1, 100, ok);
        stub_hang = 1'b0;
        checks++; if (!ok) begin failures++; $display("FAIL wd_timeout: dones=%0d, required 1", done_log.size()); end
        if (ok) begin
            checks++; if (done_log[0].err !== 1'b1 || done_log[0].q !== 32'd0 || done_log[0].r !== 32'd0 || done_log[0].id != 1) begin
                failures++;
                $display("FAIL wd_result: err=%b q=%h r=%h id=%0d, required 1 0 0 1",
                         done_log[0].err, done_log[0].q, done_log[0].r, done_log[0].id); end
            checks++; if (ack_cyc.size() != 1 || done_log[0].cyc - ack_cyc[0] != TO + 1) begin failures++;
                $display("FAIL wd_latency: done %0d cycles after ack, required %0d", done_log[0].cyc - ack_cyc[0], TO + 1); end
            checks++; if (done_log[0].start !== 1'b0) begin failures++;
                $display("FAIL wd_start: div_start=%b in RESP, required 0", done_log[0].start); end
        end
        clear_logs();
        set_op(3, 32'd50, 32'hFFFF_FFFD);
        req = 4'b1000;
        wait_dones(1, 50, ok);
        checks++; if (!ok || done_log[0].err !== 1'b0 || done_log[0].q !== 32'hFFFF_FFF0 || done_log[0].r !== 32'd2) begin
            failures++;
            $display("FAIL wd_recover: ok=%0d err=%b q=%0d r=%0d, required err 0 q -16 r 2",
                     ok, done_log[0].err, $signed(done_log[0].q), $signed(done_log[0].r)); end
    endtask

    task automatic test_reset_mid_busy();
        int t, last;
        do_reset();
        stub_hang = 1'b1;
        set_op(2, 32'd999, 32'd3);
        req = 4'b0100;
        t = 0;
        while (ack_log.size() == 0 && t < 20) begin tick(); t++; end
        repeat (3) tick();
        checks++; if (ack_log.size() != 1 || div_start !== 1'b1) begin failures++;
            $display("FAIL midrst_busy: acks=%0d div_start=%b, required 1 1", ack_log.size(), div_start); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        stub_hang = 1'b0;
        checks++; if (div_start !== 1'b0 || done !== '0 || ack !== '0 || rsp_err !== 1'b0 ||
                      {rsp_quotient, rsp_remainder, rsp_id, div_dividend, div_divisor} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: start=%b done=%b ack=%b err=%b q=%h r=%h id=%0d dd=%h dv=%h, required all 0",
                     div_start, done, ack, rsp_err, rsp_quotient, rsp_remainder, rsp_id, div_dividend, div_divisor); end
        repeat (20) tick();
        checks++; if (done_log.size() != 0) begin failures++;
            $display("FAIL midrst_lost: dones=%0d, required 0", done_log.size()); end
        clear_logs();
        rand_op(0); rand_op(3);
        req = 4'b1001;
        check_round("midrst_after", 4'b1001, NR - 1, last);
    endtask

    initial begin
        rst = 1'b0; req = '0; req_dividend = '0; req_divisor = '0;
        for (int i = 0; i < NR; i++) begin opa[i] = '0; opb[i] = 32'd1; end
        test_reset();
        test_single();
        test_signs();
        test_back_to_back();
        test_fairness();
        test_random();
        test_timeout();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
